// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32 control unit.
//   aluop_t       - ALU operation code carried to EX
//   alusrc_t      - ALU operand-B select (rs2 / imm / zero)
//   regsel_t      - writeback mux select (ALU / GPIO in / imm)
//   div_state_t   - divide stall FSM states (only used with CTRL_MEXT_EN)
//   ctrl_bundle_t - full decoded control word, BUBBLE is its all-zero value
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [3:0] {
        AluAnd    = 4'b0000,
        AluXor    = 4'b0001,
        AluOr     = 4'b0010,
        AluAdd    = 4'b0011,
        AluSub    = 4'b0100,
        AluSll    = 4'b0101,
        AluSrl    = 4'b0110,
        AluSra    = 4'b0111,
        AluSlt    = 4'b1000,
        AluSltu   = 4'b1001,
        AluMul    = 4'b1010,
        AluMulh   = 4'b1011,
        AluMulhsu = 4'b1100,
        AluMulhu  = 4'b1101,
        AluDiv    = 4'b1110,
        AluRem    = 4'b1111
    } aluop_t;

    typedef enum logic [1:0] {
        AluSrcRs2  = 2'b00,
        AluSrcImm  = 2'b01,
        AluSrcZero = 2'b10
    } alusrc_t;

    typedef enum logic [1:0] {
        RegSelAlu  = 2'b00,
        RegSelGpio = 2'b01,
        RegSelImm  = 2'b10
    } regsel_t;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } div_state_t;

    typedef struct packed {
        alusrc_t     alusrc;
        aluop_t      aluop;
        logic        div_signed;
        logic        regwrite;
        regsel_t     regsel;
        logic        gpio_we;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    function automatic logic is_divide(aluop_t op);
        return (op == AluDiv) || (op == AluRem);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational RV32I (+ optional M) decoder.
//   instr - instruction word entering EX
//   ctrl  - decoded control bundle; illegal encodings give BUBBLE with illegal=1
// Build option: CTRL_MEXT_EN enables decoding of funct7=0000001 (MUL..REMU).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter logic [11:0] CSR_IO_IN  = 12'hF00,
    parameter logic [11:0] CSR_IO_OUT = 12'hF02
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        legal;
    ctrl_bundle_t c;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        c     = BUBBLE;
        legal = 1'b0;
        c.rd  = rd;
        case (opcode)
            OPC_OP: begin
                c.regwrite = 1'b1;
                c.alusrc   = AluSrcRs2;
                c.regsel   = RegSelAlu;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  c.aluop = AluAdd;
                        3'b001:  c.aluop = AluSll;
                        3'b010:  c.aluop = AluSlt;
                        3'b011:  c.aluop = AluSltu;
                        3'b100:  c.aluop = AluXor;
                        3'b101:  c.aluop = AluSrl;
                        3'b110:  c.aluop = AluOr;
                        default: c.aluop = AluAnd;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        legal   = 1'b1;
                        c.aluop = AluSub;
                    end else if (funct3 == 3'b101) begin
                        legal   = 1'b1;
                        c.aluop = AluSra;
                    end
                end
`ifdef CTRL_MEXT_EN
                else if (funct7 == F7_MEXT) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000: c.aluop = AluMul;
                        3'b001: c.aluop = AluMulh;
                        3'b010: c.aluop = AluMulhsu;
                        3'b011: c.aluop = AluMulhu;
                        3'b100: begin c.aluop = AluDiv; c.div_signed = 1'b1; end
                        3'b101: c.aluop = AluDiv;
                        3'b110: begin c.aluop = AluRem; c.div_signed = 1'b1; end
                        default: c.aluop = AluRem;
                    endcase
                end
`endif
            end
            OPC_OPIMM: begin
                c.regwrite = 1'b1;
                c.alusrc   = AluSrcImm;
                c.regsel   = RegSelAlu;
                c.imm      = imm_i;
                legal      = 1'b1;
                case (funct3)
                    3'b000: c.aluop = AluAdd;
                    3'b010: c.aluop = AluSlt;
                    3'b011: c.aluop = AluSltu;
                    3'b100: c.aluop = AluXor;
                    3'b110: c.aluop = AluOr;
                    3'b111: c.aluop = AluAnd;
                    3'b001: begin
                        c.aluop = AluSll;
                        legal   = (funct7 == F7_BASE);
                    end
                    default: begin
                        // funct3=101: bit 30 picks SRAI; only the two exact funct7 forms are legal
                        c.aluop = instr[30] ? AluSra : AluSrl;
                        legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                c.regwrite = 1'b1;
                c.alusrc   = AluSrcZero;
                c.aluop    = AluAdd;
                c.regsel   = RegSelImm;
                c.imm      = imm_u;
                legal      = 1'b1;
            end
            OPC_SYSTEM: begin
                if (funct3 == F3_CSRRW) begin
                    if (instr[31:20] == CSR_IO_IN) begin
                        c.regwrite = 1'b1;
                        c.regsel   = RegSelGpio;
                        legal      = 1'b1;
                    end else if (instr[31:20] == CSR_IO_OUT) begin
                        c.gpio_we = 1'b1;
                        legal     = 1'b1;
                    end
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            c         = BUBBLE;
            c.illegal = 1'b1;
        end
        if (c.rd == 5'd0) begin
            c.regwrite = 1'b0;
        end
        ctrl = c;
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control unit for the 3-stage RV32 core (IF | EX | WB).
// Decodes instr_i, registers the control bundle into EX and WB stages, and stalls
// IF/EX while a multicycle divide occupies EX.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   instr_i, instr_valid_i, flush_i            - instruction entering EX, bubble, squash
//   alusrc_EX .. illegal_EX                    - EX-stage control outputs
//   stall_o                                    - hold IF and EX
//   regwrite_WB, regsel_WB, rd_WB              - WB-stage control outputs
// Build option: CTRL_MEXT_EN adds M-extension decode and the divide stall FSM;
// without it stall_o and div_signed_EX are constant 0.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DIV_LATENCY = 33,
    parameter logic [11:0] CSR_IO_IN   = 12'hF00,
    parameter logic [11:0] CSR_IO_OUT  = 12'hF02
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    input  logic            flush_i,
    output logic [1:0]      alusrc_EX,
    output logic [3:0]      aluop_EX,
    output logic            div_signed_EX,
    output logic            regwrite_EX,
    output logic [1:0]      regsel_EX,
    output logic            gpio_we_EX,
    output logic [4:0]      rd_EX,
    output logic [XLEN-1:0] imm_EX,
    output logic            illegal_EX,
    output logic            stall_o,
    output logic            regwrite_WB,
    output logic [1:0]      regsel_WB,
    output logic [4:0]      rd_WB
);

    ctrl_bundle_t dec;
    ctrl_bundle_t ex_q;
    logic         wb_regwrite_q;
    regsel_t      wb_regsel_q;
    logic [4:0]   wb_rd_q;
    logic         stall;

    ctrl_decode #(
        .CSR_IO_IN  (CSR_IO_IN),
        .CSR_IO_OUT (CSR_IO_OUT)
    ) u_decode (
        .instr (instr_i),
        .ctrl  (dec)
    );

`ifdef CTRL_MEXT_EN
    localparam int unsigned CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (DIV_LATENCY > 1) ? CNT_W'(DIV_LATENCY - 2) : '0;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Only a divide actually loaded into EX (stall is 0 in IDLE) starts the count
                    if ((DIV_LATENCY > 1) && instr_valid_i && is_divide(dec.aluop)) begin
                        state_d = StBusy;
                        cnt_d   = CNT_INIT;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign stall = (state_q == StBusy);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else if (flush_i || !stall) begin
            ex_q <= (flush_i || !instr_valid_i) ? BUBBLE : dec;
        end
    end

    // During a stall WB takes bubbles so the held divide retires exactly once
    always_ff @(posedge clk) begin
        if (!rst_n || stall) begin
            wb_regwrite_q <= 1'b0;
            wb_regsel_q   <= RegSelAlu;
            wb_rd_q       <= 5'd0;
        end else begin
            wb_regwrite_q <= ex_q.regwrite;
            wb_regsel_q   <= ex_q.regsel;
            wb_rd_q       <= ex_q.rd;
        end
    end

    assign alusrc_EX     = ex_q.alusrc;
    assign aluop_EX      = ex_q.aluop;
    // Decoder only sets div_signed with CTRL_MEXT_EN, so this is constant 0 otherwise
    assign div_signed_EX = ex_q.div_signed;
    assign regwrite_EX   = ex_q.regwrite;
    assign regsel_EX     = ex_q.regsel;
    assign gpio_we_EX    = ex_q.gpio_we;
    assign rd_EX         = ex_q.rd;
    assign imm_EX        = XLEN'($signed(ex_q.imm));
    assign illegal_EX    = ex_q.illegal;
    assign stall_o       = stall;
    assign regwrite_WB   = wb_regwrite_q;
    assign regsel_WB     = wb_regsel_q;
    assign rd_WB         = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        flush_i;
    logic [1:0]  alusrc_EX;
    logic [3:0]  aluop_EX;
    logic        div_signed_EX;
    logic        regwrite_EX;
    logic [1:0]  regsel_EX;
    logic        gpio_we_EX;
    logic [4:0]  rd_EX;
    logic [31:0] imm_EX;
    logic        illegal_EX;
    logic        stall_o;
    logic        regwrite_WB;
    logic [1:0]  regsel_WB;
    logic [4:0]  rd_WB;

    int n_checks = 0;
    int n_fail   = 0;

    logic [57:0] all_outs;
    assign all_outs = {alusrc_EX, aluop_EX, div_signed_EX, regwrite_EX, regsel_EX, gpio_we_EX,
                       rd_EX, imm_EX, illegal_EX, stall_o, regwrite_WB, regsel_WB, rd_WB};

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_LUI   = 32'h12345237;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_BADSH = 32'h2030D093;
    localparam logic [31:0] I_CSRIN = 32'hF00012F3;
    localparam logic [31:0] I_CSROU = 32'hF0231073;
    localparam logic [31:0] I_CSRBD = 32'hF0131073;
    localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_DIV   = 32'h0220C3B3;

    ctrl_pipe_unit #(
        .XLEN        (32),
        .DIV_LATENCY (4),
        .CSR_IO_IN   (12'hF00),
        .CSR_IO_OUT  (12'hF02)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .flush_i       (flush_i),
        .alusrc_EX     (alusrc_EX),
        .aluop_EX      (aluop_EX),
        .div_signed_EX (div_signed_EX),
        .regwrite_EX   (regwrite_EX),
        .regsel_EX     (regsel_EX),
        .gpio_we_EX    (gpio_we_EX),
        .rd_EX         (rd_EX),
        .imm_EX        (imm_EX),
        .illegal_EX    (illegal_EX),
        .stall_o       (stall_o),
        .regwrite_WB   (regwrite_WB),
        .regsel_WB     (regsel_WB),
        .rd_WB         (rd_WB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_i = I_ADDI; instr_valid_i = 1'b1; flush_i = 1'b0;
        step();
        step();
        n_checks++;
        if (all_outs !== 58'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", all_outs); n_fail++;
        end
        rst_n = 1'b1; instr_valid_i = 1'b0;
        step();
        n_checks++;
        if (stall_o !== 1'b0) begin $display("FAIL reset_stall: got %b expected 0", stall_o); n_fail++; end
    endtask

    task automatic test_addi();
        instr_i = I_ADDI; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({regwrite_EX, alusrc_EX, aluop_EX, rd_EX} !== {1'b1, 2'b01, 4'b0011, 5'd1}) begin
            $display("FAIL addi_ex_ctrl: got %b expected %b",
                     {regwrite_EX, alusrc_EX, aluop_EX, rd_EX}, {1'b1, 2'b01, 4'b0011, 5'd1});
            n_fail++;
        end
        n_checks++;
        if (imm_EX !== 32'd5) begin $display("FAIL addi_imm: got %h expected 5", imm_EX); n_fail++; end
        instr_valid_i = 1'b0;
        step();
        n_checks++;
        if ({regwrite_WB, regsel_WB, rd_WB} !== {1'b1, 2'b00, 5'd1}) begin
            $display("FAIL addi_wb: got %b expected %b", {regwrite_WB, regsel_WB, rd_WB},
                     {1'b1, 2'b00, 5'd1});
            n_fail++;
        end
        n_checks++;
        if ({regwrite_EX, aluop_EX, illegal_EX} !== 6'd0) begin
            $display("FAIL bubble_ex: got %b expected 0", {regwrite_EX, aluop_EX, illegal_EX});
            n_fail++;
        end
    endtask

    task automatic test_alu_lui();
        instr_i = I_SUB; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({aluop_EX, alusrc_EX, regwrite_EX, rd_EX} !== {4'b0100, 2'b00, 1'b1, 5'd3}) begin
            $display("FAIL sub_ex: got %b expected %b", {aluop_EX, alusrc_EX, regwrite_EX, rd_EX},
                     {4'b0100, 2'b00, 1'b1, 5'd3});
            n_fail++;
        end
        instr_i = I_LUI;
        step();
        n_checks++;
        if ({regsel_EX, alusrc_EX, regwrite_EX, rd_EX} !== {2'b10, 2'b10, 1'b1, 5'd4}) begin
            $display("FAIL lui_ctrl: got %b expected %b", {regsel_EX, alusrc_EX, regwrite_EX, rd_EX},
                     {2'b10, 2'b10, 1'b1, 5'd4});
            n_fail++;
        end
        n_checks++;
        if (imm_EX !== 32'h12345000) begin
            $display("FAIL lui_imm: got %h expected 12345000", imm_EX); n_fail++;
        end
        instr_i = I_SRAI;
        step();
        n_checks++;
        if ({aluop_EX, alusrc_EX, illegal_EX, imm_EX} !== {4'b0111, 2'b01, 1'b0, 32'h00000403}) begin
            $display("FAIL srai: got %h expected %h", {aluop_EX, alusrc_EX, illegal_EX, imm_EX},
                     {4'b0111, 2'b01, 1'b0, 32'h00000403});
            n_fail++;
        end
        instr_i = I_BADSH;
        step();
        n_checks++;
        if ({illegal_EX, regwrite_EX, aluop_EX} !== {1'b1, 1'b0, 4'b0000}) begin
            $display("FAIL bad_shift_illegal: got %b expected 100000",
                     {illegal_EX, regwrite_EX, aluop_EX});
            n_fail++;
        end
        idle2();
    endtask

    task automatic test_csr();
        instr_i = I_CSRIN; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({regsel_EX, regwrite_EX, gpio_we_EX, rd_EX} !== {2'b01, 1'b1, 1'b0, 5'd5}) begin
            $display("FAIL csr_in: got %b expected %b", {regsel_EX, regwrite_EX, gpio_we_EX, rd_EX},
                     {2'b01, 1'b1, 1'b0, 5'd5});
            n_fail++;
        end
        instr_i = I_CSROU;
        step();
        n_checks++;
        if ({gpio_we_EX, regwrite_EX, illegal_EX} !== 3'b100) begin
            $display("FAIL csr_out: got %b expected 100", {gpio_we_EX, regwrite_EX, illegal_EX});
            n_fail++;
        end
        n_checks++;
        if ({regwrite_WB, regsel_WB, rd_WB} !== {1'b1, 2'b01, 5'd5}) begin
            $display("FAIL csr_in_wb: got %b expected %b", {regwrite_WB, regsel_WB, rd_WB},
                     {1'b1, 2'b01, 5'd5});
            n_fail++;
        end
        instr_i = I_CSRBD;
        step();
        n_checks++;
        if ({illegal_EX, gpio_we_EX, regwrite_EX} !== 3'b100) begin
            $display("FAIL csr_unknown: got %b expected 100", {illegal_EX, gpio_we_EX, regwrite_EX});
            n_fail++;
        end
        idle2();
    endtask

    task automatic test_illegal_x0();
        instr_i = I_ONES; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({illegal_EX, regwrite_EX, aluop_EX, rd_EX} !== {1'b1, 1'b0, 4'b0000, 5'd0}) begin
            $display("FAIL all_ones_illegal: got %b expected %b",
                     {illegal_EX, regwrite_EX, aluop_EX, rd_EX}, {1'b1, 1'b0, 4'b0000, 5'd0});
            n_fail++;
        end
        instr_i = I_NOP;
        step();
        n_checks++;
        if ({illegal_EX, regwrite_EX, aluop_EX} !== {1'b0, 1'b0, 4'b0011}) begin
            $display("FAIL addi_x0: got %b expected 0000011", {illegal_EX, regwrite_EX, aluop_EX});
            n_fail++;
        end
        // flush squashes a valid instruction
        instr_i = I_ADDI; flush_i = 1'b1;
        step();
        n_checks++;
        if ({regwrite_EX, aluop_EX, rd_EX, illegal_EX} !== 11'd0) begin
            $display("FAIL flush_bubble: got %b expected 0", {regwrite_EX, aluop_EX, rd_EX, illegal_EX});
            n_fail++;
        end
        idle2();
    endtask

`ifdef CTRL_MEXT_EN
    task automatic test_divide();
        int stall_cnt;
        int wb_div;
        stall_cnt = 0;
        wb_div    = 0;
        instr_i = I_DIV; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({aluop_EX, div_signed_EX, regwrite_EX, rd_EX} !== {4'b1110, 1'b1, 1'b1, 5'd7}) begin
            $display("FAIL div_ex: got %b expected %b", {aluop_EX, div_signed_EX, regwrite_EX, rd_EX},
                     {4'b1110, 1'b1, 1'b1, 5'd7});
            n_fail++;
        end
        instr_i = I_ADDI;
        for (int i = 0; i < 8; i++) begin
            if (stall_o === 1'b1) begin
                stall_cnt++;
                n_checks++;
                if (aluop_EX !== 4'b1110 || regwrite_WB !== 1'b0) begin
                    $display("FAIL div_hold: cycle %0d aluop %b wb %b expected 1110 0", i, aluop_EX,
                             regwrite_WB);
                    n_fail++;
                end
            end
            if (regwrite_WB === 1'b1 && rd_WB === 5'd7) wb_div++;
            step();
        end
        n_checks++;
        if (stall_cnt != 3) begin
            $display("FAIL div_stall_len: got %0d expected 3", stall_cnt); n_fail++;
        end
        n_checks++;
        if (wb_div != 1) begin $display("FAIL div_wb_once: got %0d expected 1", wb_div); n_fail++; end
        idle2();
    endtask

    task automatic test_flush_div();
        instr_i = I_DIV; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if (stall_o !== 1'b1) begin $display("FAIL flush_pre_stall: got %b expected 1", stall_o); n_fail++; end
        flush_i = 1'b1;
        step();
        n_checks++;
        if ({stall_o, regwrite_EX, aluop_EX, illegal_EX, regwrite_WB} !== 8'd0) begin
            $display("FAIL flush_div: got %b expected 0",
                     {stall_o, regwrite_EX, aluop_EX, illegal_EX, regwrite_WB});
            n_fail++;
        end
        flush_i = 1'b0;
        idle2();
        n_checks++;
        if (stall_o !== 1'b0) begin $display("FAIL flush_idle: got %b expected 0", stall_o); n_fail++; end
    endtask

    task automatic test_reset_div();
        instr_i = I_DIV; instr_valid_i = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (all_outs !== 58'd0) begin
            $display("FAIL reset_mid_div: got %h expected 0", all_outs); n_fail++;
        end
        rst_n = 1'b1; instr_valid_i = 1'b0;
        step();
        n_checks++;
        if (stall_o !== 1'b0) begin $display("FAIL reset_div_stall: got %b expected 0", stall_o); n_fail++; end
    endtask

    task automatic test_back_to_back();
        instr_i = I_DIV; instr_valid_i = 1'b1;
        step();
        step();
        step();
        step();
        n_checks++;
        if ({stall_o, aluop_EX} !== {1'b0, 4'b1110}) begin
            $display("FAIL b2b_gap: got %b expected 01110", {stall_o, aluop_EX}); n_fail++;
        end
        step();
        n_checks++;
        if ({stall_o, regwrite_WB, rd_WB, aluop_EX} !== {1'b1, 1'b1, 5'd7, 4'b1110}) begin
            $display("FAIL b2b_restart: got %b expected %b", {stall_o, regwrite_WB, rd_WB, aluop_EX},
                     {1'b1, 1'b1, 5'd7, 4'b1110});
            n_fail++;
        end
        instr_valid_i = 1'b0; flush_i = 1'b1;
        step();
        idle2();
    endtask
`else
    task automatic test_no_mext();
        instr_i = I_DIV; instr_valid_i = 1'b1;
        step();
        n_checks++;
        if ({illegal_EX, aluop_EX, regwrite_EX, div_signed_EX, stall_o} !== 8'b1000_0000) begin
            $display("FAIL mext_disabled: got %b expected 10000000",
                     {illegal_EX, aluop_EX, regwrite_EX, div_signed_EX, stall_o});
            n_fail++;
        end
        step();
        n_checks++;
        if (stall_o !== 1'b0) begin $display("FAIL mext_no_stall: got %b expected 0", stall_o); n_fail++; end
        idle2();
    endtask
`endif

    initial begin
        rst_n = 1'b0; instr_i = '0; instr_valid_i = 1'b0; flush_i = 1'b0;
        test_reset();
        test_addi();
        test_alu_lui();
        test_csr();
        test_illegal_x0();
`ifdef CTRL_MEXT_EN
        test_divide();
        test_flush_div();
        test_reset_div();
        test_back_to_back();
`else
        test_no_mext();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Second-generation control unit for the 3-stage RV32 core (IF | EX | WB).
- Decodes the instruction entering EX and registers the control bundle into EX-stage and WB-stage pipeline registers.
- Adds what the first generation lacked: full RV32I ALU/LUI/CSRRW decode, rd=x0 write suppression, illegal-instruction flag, flush, and a counter-based stall FSM for multicycle DIV/REM.
- Sits between the instruction memory output and the regfile/ALU/GPIO datapath.

Parameters:
- XLEN, 32, datapath and immediate width.
- DIV_LATENCY, 33, total EX cycles a DIV/DIVU/REM/REMU occupies. Must be >= 1; 1 means no stall.
- CSR_IO_IN, 12'hF00, CSR address read from GPIO input (io0).
- CSR_IO_OUT, 12'hF02, CSR address written to GPIO output (io2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- instr_i  in  32  instruction entering EX
- instr_valid_i  in  1  instr_i is valid; low inserts a bubble
- flush_i  in  1  squash the instruction entering EX; abort any divide
- alusrc_EX  out  2  00 = rs2, 01 = imm_EX, 10 = zero (LUI)
- aluop_EX  out  4  ALU operation code
- div_signed_EX  out  1  1 for DIV/REM, 0 for DIVU/REMU
- regwrite_EX  out  1  EX instruction writes rd
- regsel_EX  out  2  00 = ALU, 01 = GPIO in, 10 = imm_EX
- gpio_we_EX  out  1  write rs1 to GPIO out
- rd_EX  out  5  destination register
- imm_EX  out  XLEN  decoded immediate
- illegal_EX  out  1  EX slot holds an undecodable instruction
- stall_o  out  1  hold IF and EX
- regwrite_WB  out  1  WB-stage write enable
- regsel_WB  out  2  WB-stage mux select
- rd_WB  out  5  WB-stage destination

Behaviour:
- Reset: on a clk edge with rst_n=0, every output is 0, the FSM is IDLE, and the counter is 0. Reset mid-divide aborts the divide immediately.
- aluop encoding:
  - AND 0000, XOR 0001, OR 0010, ADD 0011, SUB 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
  - MUL 1010, MULH 1011, MULHSU 1100, MULHU 1101, DIV/DIVU 1110, REM/REMU 1111
- Decode is combinational from instr_i. The EX registers load on each edge where stall_o=0. Latency is 1 cycle to EX and 2 cycles to WB.
- R-type (0110011):
  - regwrite=1, alusrc=00, regsel=00.
  - funct7 0000000 selects ADD/XOR/OR/AND/SLL/SRL/SLT/SLTU; 0100000 selects SUB/SRA.
  - Any other funct7/funct3 combination is illegal.
- I-ALU (0010011):
  - regwrite=1, alusrc=01, imm = sign-extended [31:20].
  - For funct3 101, instr[30] selects SRA (1) or SRL (0).
  - For shift-immediates, instr[31:25] must be 0000000, except 0100000 for SRAI; anything else is illegal.
- LUI (0110111): regwrite=1, regsel=10, imm = {instr[31:12], 12'b0}.
- CSRRW (1110011, funct3 001):
  - imm12=CSR_IO_IN: regwrite=1, regsel=01.
  - imm12=CSR_IO_OUT: gpio_we=1, regwrite=0.
  - Any other CSR is illegal.
- Illegal opcode or field: all control outputs 0 (bubble), illegal_EX=1.
- rd=0 forces regwrite_EX=0.
- instr_valid_i=0 or flush_i=1: EX loads a bubble (all controls 0, illegal_EX=0). flush_i overrides stall_o and returns the FSM to IDLE.
- Divide FSM (IDLE, BUSY):
  - A divide loaded into EX with DIV_LATENCY>1 moves the FSM IDLE->BUSY with cnt=DIV_LATENCY-2.
  - stall_o = (state==BUSY). It is Moore-registered, so the first stalled edge is the one after the divide is captured.
  - In BUSY, cnt decrements; at cnt==0 the FSM returns to IDLE.
  - While stall_o=1, the EX registers hold and instr_i/instr_valid_i are ignored.
- WB registers:
  - Load from EX when stall_o=0.
  - Load a bubble when stall_o=1, so the divide writes back exactly once, after the stall.
- Back-to-back divides: the second divide is captured on the edge where stall_o falls and restarts the FSM.

Optional Feature:
- CTRL_MEXT_EN defined: funct7 0000001 decodes MUL..REMU, and the divide FSM and counter are present.
- CTRL_MEXT_EN undefined: funct7 0000001 is illegal, no FSM or counter is synthesised, stall_o is tied to 0, and div_signed_EX is tied to 0.

Decomposition:
- Package ctrl_pkg holds: aluop_t enum, alusrc_t/regsel_t enums, opcode localparams, and a ctrl_bundle_t struct (alusrc, aluop, div_signed, regwrite, regsel, gpio_we, rd, imm, illegal) with a BUBBLE constant.
- One sub-module, ctrl_decode: purely combinational mapping from instr to ctrl_bundle_t. The top level owns the pipeline registers, stall FSM and flush.

Test Plan:
- 0x00500093 (addi x1,x0,5) -> next cycle regwrite_EX=1, alusrc_EX=01, aluop_EX=0011, rd_EX=1, imm_EX=5; cycle after that, regwrite_WB=1, rd_WB=1.
- 0x402081B3 (sub x3,x1,x2) -> aluop_EX=0100; 0x12345237 (lui x4) -> regsel_EX=10, imm_EX=0x12345000.
- 0xF00012F3 (csrrw x5,0xF00,x0) -> regsel_EX=01, regwrite_EX=1; 0xF0231073 (csrrw x0,0xF02,x6) -> gpio_we_EX=1, regwrite_EX=0.
- With CTRL_MEXT_EN and DIV_LATENCY=4, 0x0220C3B3 (div x7,x1,x2) -> aluop_EX=1110, div_signed_EX=1, stall_o high exactly 3 cycles; regwrite_WB=1 only once, afterwards.
- Divide in BUSY then flush_i=1 -> stall_o=0 next cycle, EX holds a bubble. Repeat with rst_n=0 instead of flush -> all outputs 0.
- 0xFFFFFFFF -> illegal_EX=1 and regwrite_EX=0. 0x00000013 (addi x0) -> regwrite_EX=0, illegal_EX=0.
